// File: rtl/spi_slave_if.sv
// SPI mode-0 slave endpoint in the PCLK domain: oversampled SCK/SS_n/MOSI,
// MSB-first shift registers, a single TX holding register and a one-cycle RX strobe.
module spi_slave_if #(
    parameter int                 DATA_W      = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  IDLE_FILL   = 8'hFF
) (
    input  logic              i_PCLK,
    input  logic              i_PRESETn,
    input  logic              i_SCK,
    input  logic              i_SS_n,
    input  logic              i_MOSI,
    output logic              o_MISO,
    output logic              o_MISO_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_wr,
    output logic              o_tx_empty,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_busy,
    output logic              o_underrun,
    output logic              o_tx_ovr,
    input  logic              i_clr_flags
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic sck_s, ss_s, mosi_s;
    logic sck_q, ss_q;
    logic sck_rise, sck_fall, ss_fall, ss_rise;

    logic [CNT_W-1:0]  bit_cnt;
    logic              byte_done;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;

    logic              load, shift, capture, abort;
    logic [DATA_W-1:0] load_value;
    logic              underrun_set, ovr_set;
    logic [DATA_W-1:0] rx_next;

    // Equal-depth synchronizers keep SCK, SS_n and MOSI cycle-aligned; SS_n idles high.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SCK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_MOSI};
            sck_q     <= sck_s;
            ss_q      <= ss_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_q;
    assign sck_fall = ~sck_s &  sck_q;
    assign ss_fall  = ~ss_s  &  ss_q;
    assign ss_rise  =  ss_s  & ~ss_q;

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    capture = sck_rise;
                    if (sck_fall) begin
                        load  = byte_done;
                        shift = ~byte_done;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A load drains the holding register, or falls back to the idle pattern when it is empty.
    always_comb begin
        load_value   = hold_full ? hold_data : IDLE_FILL;
        underrun_set = load & ~hold_full;
        ovr_set      = i_tx_wr & hold_full & ~load;
        rx_next      = {rx_shift[DATA_W-2:0], mosi_s};
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            rx_shift   <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            if (abort) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                rx_shift  <= '0;
            end else begin
                if (load) begin
                    byte_done <= 1'b0;
                    if (state == IDLE) begin
                        bit_cnt <= '0;
                    end
                end
                if (capture) begin
                    rx_shift <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt    <= '0;
                        byte_done  <= 1'b1;
                        o_rx_data  <= rx_next;
                        o_rx_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            tx_shift <= '0;
            o_MISO   <= 1'b0;
        end else if (load) begin
            tx_shift <= load_value;
            o_MISO   <= load_value[DATA_W-1];
        end else if (shift) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            o_MISO   <= tx_shift[DATA_W-2];
        end
    end

    // A write in the same cycle as a load lands after the drain, so the new byte survives.
    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            o_underrun <= 1'b0;
            o_tx_ovr   <= 1'b0;
        end else begin
            if (load) begin
                hold_full <= 1'b0;
            end
            if (i_tx_wr) begin
                hold_data <= i_tx_data;
                hold_full <= 1'b1;
            end
            o_underrun <= underrun_set | (o_underrun & ~i_clr_flags);
            o_tx_ovr   <= ovr_set      | (o_tx_ovr   & ~i_clr_flags);
        end
    end

    assign o_tx_empty = ~hold_full;
    assign o_busy     = (state == ACTIVE);
    assign o_MISO_oe  = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: an SPI mode-0 master plus a transaction-level
// model of the holding register and flags, with scripted and randomized frames.
module tb_spi_slave_if;

    localparam int HALF = 6;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_data = '0;
    logic       tx_wr = 1'b0;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy, underrun, tx_ovr;
    logic       clr_flags = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    spi_slave_if dut (
        .i_PCLK      (pclk),
        .i_PRESETn   (rst_n),
        .i_SCK       (sck),
        .i_SS_n      (ss_n),
        .i_MOSI      (mosi),
        .o_MISO      (miso),
        .o_MISO_oe   (miso_oe),
        .i_tx_data   (tx_data),
        .i_tx_wr     (tx_wr),
        .o_tx_empty  (tx_empty),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_busy      (busy),
        .o_underrun  (underrun),
        .o_tx_ovr    (tx_ovr),
        .i_clr_flags (clr_flags)
    );

    always #5 pclk = ~pclk;

    // Reference model: one-deep holding register, sticky flags, byte currently on MISO.
    logic [7:0] m_hold;
    bit         m_full, m_underrun, m_ovr;
    logic [7:0] cur_tx;
    logic [7:0] rx_q[$];

    always @(negedge pclk) begin
        if (rst_n && rx_valid) rx_q.push_back(rx_data);
    end

    function automatic void model_reset();
        m_hold = '0; m_full = 0; m_underrun = 0; m_ovr = 0;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        if (m_full) m_ovr = 1;
        m_hold = d;
        m_full = 1;
    endfunction

    function automatic logic [7:0] model_load();
        if (m_full) begin
            m_full = 0;
            return m_hold;
        end
        m_underrun = 1;
        return 8'hFF;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge pclk);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge pclk);
        tx_wr   = 1'b0;
        model_write(d);
    endtask

    task automatic clear_flags();
        @(negedge pclk);
        clr_flags = 1'b1;
        @(negedge pclk);
        clr_flags = 1'b0;
        m_underrun = 0;
        m_ovr = 0;
    endtask

    task automatic frame_start();
        @(negedge pclk);
        ss_n = 1'b0;
        cur_tx = model_load();
        wait_clk(HALF);
        vectors++;
        if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_start busy/oe: got %b/%b want 1/1", busy, miso_oe);
        end
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(2 * HALF);
        vectors++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end busy/oe: got %b/%b want 0/0", busy, miso_oe);
        end
    endtask

    // Clocks nbits of one byte; a full byte is checked for MISO and RX, a partial one for MISO only.
    task automatic xfer(input logic [7:0] mosi_b, input int nbits, input bit wr_mid,
                        input logic [7:0] wr_d);
        logic [7:0] miso_b;
        logic [7:0] want_tx;
        int q0;
        miso_b  = '0;
        want_tx = cur_tx;
        q0      = rx_q.size();
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_b[7-i];
            wait_clk(HALF);
            miso_b[7-i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
            if (wr_mid && i == 3) tx_write(wr_d);
        end
        if (nbits == 8) begin
            wait_clk(HALF);
            cur_tx = model_load();
            vectors++;
            if (miso_b !== want_tx) begin
                miscompares++;
                $display("FAIL miso_byte: got %02h want %02h", miso_b, want_tx);
            end
            vectors++;
            if (rx_q.size() !== q0 + 1) begin
                miscompares++;
                $display("FAIL rx_valid_count: got %0d want %0d", rx_q.size() - q0, 1);
            end else begin
                vectors++;
                if (rx_q[q0] !== mosi_b) begin
                    miscompares++;
                    $display("FAIL rx_data: got %02h want %02h", rx_q[q0], mosi_b);
                end
            end
        end else begin
            vectors++;
            if ((miso_b >> (8 - nbits)) !== (want_tx >> (8 - nbits))) begin
                miscompares++;
                $display("FAIL miso_partial: got %02h want %02h (top %0d bits)",
                         miso_b, want_tx, nbits);
            end
        end
    endtask

    task automatic check_flags(input string tag);
        vectors++;
        if (underrun !== m_underrun || tx_ovr !== m_ovr || tx_empty !== !m_full) begin
            miscompares++;
            $display("FAIL flags_%s: got und=%b ovr=%b empty=%b want und=%b ovr=%b empty=%b",
                     tag, underrun, tx_ovr, tx_empty, m_underrun, m_ovr, !m_full);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (miso !== 1'b0 || miso_oe !== 1'b0 || tx_empty !== 1'b1 || rx_data !== 8'h00 ||
            rx_valid !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0 || tx_ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got miso=%b oe=%b empty=%b rx=%02h v=%b busy=%b und=%b ovr=%b want 0 0 1 00 0 0 0 0",
                     tag, miso, miso_oe, tx_empty, rx_data, rx_valid, busy, underrun, tx_ovr);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        wait_clk(3);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 4; i++) begin
            sck = 1'b1; wait_clk(HALF);
            sck = 1'b0; wait_clk(HALF);
        end
        vectors++;
        if (rx_q.size() !== 0 || miso_oe !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sck_while_deselected: got rx_pulses=%0d oe=%b busy=%b want 0 0 0",
                     rx_q.size(), miso_oe, busy);
        end
    endtask

    task automatic test_single_frame();
        tx_write(8'hA5);
        frame_start();
        xfer(8'h3C, 8, 1'b0, 8'h00);
        frame_end();
        check_flags("single");
    endtask

    task automatic test_back_to_back();
        clear_flags();
        tx_write(8'h11);
        frame_start();
        xfer(8'h81, 8, 1'b1, 8'h22);
        xfer(8'h42, 8, 1'b1, 8'h33);
        frame_end();
        check_flags("b2b");
    endtask

    task automatic test_underrun_overrun();
        frame_start();
        xfer(8'h00, 8, 1'b0, 8'h00);
        frame_end();
        check_flags("underrun");
        tx_write(8'h01);
        tx_write(8'h02);
        check_flags("overrun");
        frame_start();
        xfer(8'h99, 8, 1'b0, 8'h00);
        frame_end();
        clear_flags();
        check_flags("cleared");
    endtask

    task automatic test_abort();
        int q0;
        q0 = rx_q.size();
        tx_write(8'h6E);
        frame_start();
        xfer(8'hFF, 5, 1'b0, 8'h00);
        frame_end();
        vectors++;
        if (rx_q.size() !== q0) begin
            miscompares++;
            $display("FAIL abort_rx_valid: got %0d pulses want 0", rx_q.size() - q0);
        end
        frame_start();
        xfer(8'hC3, 8, 1'b0, 8'h00);
        frame_end();
        check_flags("abort");
    endtask

    task automatic test_async_reset();
        tx_write(8'h77);
        frame_start();
        xfer(8'h0F, 3, 1'b0, 8'h00);
        @(negedge pclk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        rx_q.delete();
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        tx_write(8'h5A);
        frame_start();
        xfer(8'hF0, 8, 1'b0, 8'h00);
        frame_end();
        check_flags("post_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int nw, nb;
            nw = $urandom_range(0, 2);
            nb = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) tx_write(8'($urandom));
            frame_start();
            for (int b = 0; b < nb; b++) begin
                xfer(8'($urandom), 8, 1'($urandom_range(0, 1)), 8'($urandom));
            end
            frame_end();
            check_flags("random");
            if ($urandom_range(0, 1) == 1) clear_flags();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun_overrun();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
